// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory handshake, the redirect
// inputs and the decode-side queue head into one port.
//   master : the fetch_queue side (drives imem_req/imem_addr and out_*)
//   slave  : the environment side (memory, PC/branch logic, IF/ID stage)
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              deq;
  logic              out_valid;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc4;
  logic [CW-1:0]     out_count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc, deq,
    output out_valid, out_inst, out_pc4, out_count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc, deq,
    input  out_valid, out_inst, out_pc4, out_count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between PC logic and IF/ID.
// Fetches sequential words over a variable-latency req/ack memory port and
// buffers up to DEPTH {instruction, PC+4} pairs for the decode stage.
// A redirect flushes the queue, restarts fetch at redirect_pc and drops any
// response already in flight.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_queue_if.master: imem req/addr/ack/rdata, redirect/
//          redirect_pc, deq, and the queue head out_valid/inst/pc4/count
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] addrQ;
  logic [CW-1:0]     count;
  logic [PW-1:0]     head, tail;

  logic [31:0]       instMem [DEPTH];
  logic [ADDR_W-1:0] pc4Mem  [DEPTH];

  logic              push, pop, hasRoom;
  logic [CW-1:0]     countNext;
  logic [ADDR_W-1:0] addrNext;

  assign addrNext = addrQ + ADDR_W'(4);

  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    countNext = count;
    push      = (state == S_WAIT) && bus.imem_ack && !bus.redirect;
    pop       = bus.deq && (count != '0) && !bus.redirect;
    countNext = count + CW'(push) - CW'(pop);
    // Room is judged on next-cycle occupancy so a same-cycle pop lets fetch
    // continue from a full queue without a bubble.
    hasRoom   = countNext < CW'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      fetchPc <= RESET_PC;
      addrQ   <= RESET_PC;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else if (bus.redirect) begin
      count   <= '0;
      head    <= tail;
      fetchPc <= bus.redirect_pc;
      // An outstanding request must still complete on the memory side;
      // DROP keeps it asserted at the old address and discards the data.
      if (state != S_IDLE)
        state <= bus.imem_ack ? S_IDLE : S_DROP;
    end else begin
      count <= countNext;
      head  <= head + PW'(pop);
      case (state)
        S_IDLE: begin
          if (hasRoom) begin
            state <= S_WAIT;
            addrQ <= fetchPc;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            tail    <= tail + PW'(1);
            fetchPc <= addrNext;
            if (hasRoom) addrQ <= addrNext;
            else         state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.imem_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; occupancy alone says which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      instMem[tail] <= bus.imem_rdata;
      pc4Mem[tail]  <= addrNext;
    end
  end

  assign bus.imem_req  = (state != S_IDLE);
  assign bus.imem_addr = addrQ;
  assign bus.out_valid = (count != '0);
  assign bus.out_inst  = instMem[head];
  assign bus.out_pc4   = pc4Mem[head];
  assign bus.out_count = count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue. A latency-programmable
// memory model answers requests; expected request addresses and expected
// popped {pc4, inst} values are queued by each scenario and compared by a
// negedge monitor as the DUT produces them.
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk, rst;
  int   checks = 0, fails = 0;
  int   lat = 0;
  int   memCnt = 0;
  logic [31:0] reqQ [$];
  logic [31:0] expQ [$];

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Memory model: acks after `lat` wait cycles; lat=0 acks every req cycle.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || !bus.imem_req) begin
        bus.imem_ack = 1'b0; memCnt = 0;
      end else if (memCnt >= lat) begin
        bus.imem_ack = 1'b1; bus.imem_rdata = instOf(bus.imem_addr); memCnt = 0;
      end else begin
        bus.imem_ack = 1'b0; memCnt++;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (reqQ.size() == 0) chk("req_extra", 32'(reqQ.size()), 32'd1);
        else                  chk("req_addr", bus.imem_addr, reqQ.pop_front());
      end
      if (bus.deq && bus.out_valid && !bus.redirect) begin
        if (expQ.size() == 0) chk("pop_extra", 32'(expQ.size()), 32'd1);
        else begin
          logic [31:0] e;
          e = expQ.pop_front();
          chk("pop_pc4", bus.out_pc4, e);
          chk("pop_inst", bus.out_inst, instOf(e - 32'd4));
        end
      end
    end
  end

  task automatic doReset(int l);
    rst = 1'b1; lat = l; bus.deq = 1'b0; bus.redirect = 1'b0;
    tick(); tick();
    reqQ.delete(); expQ.delete();
  endtask

  task automatic pushReqs(logic [31:0] base, int n);
    for (int i = 0; i < n; i++) reqQ.push_back(base + 32'(4 * i));
  endtask

  task automatic waitCnt(int n, string tag);
    int k = 0;
    while (int'(bus.out_count) != n && k < 200) begin tick(); k++; end
    if (k >= 200) chk(tag, 32'(bus.out_count), 32'(n));
  endtask

  task automatic waitValid(string tag);
    int k = 0;
    while (!bus.out_valid && k < 200) begin tick(); k++; end
    if (k >= 200) chk(tag, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic waitReq(logic [31:0] a, string tag);
    int k = 0;
    while (!(bus.imem_req && bus.imem_addr == a) && k < 200) begin tick(); k++; end
    if (k >= 200) chk(tag, bus.imem_addr, a);
  endtask

  task automatic popN(int n, string tag);
    for (int i = 0; i < n; i++) begin
      waitValid(tag);
      bus.deq = 1'b1; tick(); bus.deq = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.deq = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // 1: reset state, zero-wait fill to full, no fifth request
    doReset(0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cnt", 32'(bus.out_count), 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    pushReqs(32'h0, 4);
    expQ = '{32'h4, 32'h8, 32'hC, 32'h10};
    rst = 1'b0;
    waitCnt(4, "t1_fill");
    tick(); tick(); tick();
    chk("t1_req", 32'(bus.imem_req), 32'd0);
    chk("t1_cnt", 32'(bus.out_count), 32'd4);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_pc4", bus.out_pc4, 32'h4);
    chk("t1_inst", bus.out_inst, instOf(32'h0));

    // 2: pop from full restarts fetch; same-cycle ack+pop holds count
    bus.deq = 1'b1; tick(); bus.deq = 1'b0;
    chk("t2_cnt", 32'(bus.out_count), 32'd3);
    chk("t2_pc4", bus.out_pc4, 32'h8);
    chk("t2_req", 32'(bus.imem_req), 32'd1);
    chk("t2_addr", bus.imem_addr, 32'h10);
    reqQ.push_back(32'h10);
    expQ.push_back(32'h14);
    bus.deq = 1'b1; tick(); bus.deq = 1'b0;
    chk("t2_same", 32'(bus.out_count), 32'd3);

    // 3: redirect while waiting on 0x8 with 3-cycle memory
    doReset(3);
    pushReqs(32'h0, 3);
    pushReqs(32'h100, 12);
    expQ = '{32'h104, 32'h108, 32'h10C};
    rst = 1'b0;
    waitReq(32'h8, "t3_w8");
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    tick(); bus.redirect = 1'b0;
    chk("t3_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_cnt", 32'(bus.out_count), 32'd0);
    chk("t3_req", 32'(bus.imem_req), 32'd1);
    chk("t3_addr", bus.imem_addr, 32'h8);
    waitValid("t3_wv");
    chk("t3_pc4", bus.out_pc4, 32'h104);
    popN(3, "t3_pop");

    // 4: redirect coincident with ack and deq at count=2
    doReset(0);
    pushReqs(32'h0, 3);
    pushReqs(32'h400, 8);
    expQ = '{32'h404, 32'h408};
    rst = 1'b0;
    waitCnt(2, "t4_c2");
    bus.redirect = 1'b1; bus.redirect_pc = 32'h400; bus.deq = 1'b1;
    tick(); bus.redirect = 1'b0; bus.deq = 1'b0;
    chk("t4_cnt", 32'(bus.out_count), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_req", 32'(bus.imem_req), 32'd0);
    tick();
    chk("t4_req2", 32'(bus.imem_req), 32'd1);
    chk("t4_addr", bus.imem_addr, 32'h400);
    waitValid("t4_wv");
    chk("t4_pc4", bus.out_pc4, 32'h404);
    popN(2, "t4_pop");

    // 5: two redirects while dropping; only the latest target is fetched
    doReset(6);
    pushReqs(32'h0, 2);
    pushReqs(32'h300, 8);
    expQ = '{32'h304, 32'h308};
    rst = 1'b0;
    waitReq(32'h4, "t5_w4");
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick(); bus.redirect = 1'b0;
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    tick(); bus.redirect = 1'b0;
    chk("t5_req", 32'(bus.imem_req), 32'd1);
    chk("t5_addr", bus.imem_addr, 32'h4);
    waitValid("t5_wv");
    chk("t5_pc4", bus.out_pc4, 32'h304);
    popN(2, "t5_pop");

    // 6: reset mid-request at count=2
    doReset(2);
    pushReqs(32'h0, 4);
    rst = 1'b0;
    waitCnt(2, "t6_c2");
    chk("t6_reqpre", 32'(bus.imem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_req", 32'(bus.imem_req), 32'd0);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_cnt", 32'(bus.out_count), 32'd0);
    chk("t6_addr", bus.imem_addr, RST_PC);
    reqQ.delete(); expQ.delete();
    pushReqs(32'h0, 2);
    expQ.push_back(32'h4);
    rst = 1'b0;
    waitReq(RST_PC, "t6_wr");
    chk("t6_first", bus.imem_addr, RST_PC);
    popN(1, "t6_pop");

    // 7: deq while empty is ignored; fetch wraps past the top of memory
    doReset(4);
    reqQ.push_back(32'h0);
    reqQ.push_back(32'hFFFF_FFF8);
    reqQ.push_back(32'hFFFF_FFFC);
    pushReqs(32'h0, 6);
    expQ = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    rst = 1'b0;
    bus.deq = 1'b1;
    tick(); tick();
    chk("t7_empty", 32'(bus.out_count), 32'd0);
    bus.deq = 1'b0;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    tick(); bus.redirect = 1'b0;
    chk("t7_drop", bus.imem_addr, 32'h0);
    waitValid("t7_wv");
    chk("t7_pc4", bus.out_pc4, 32'hFFFF_FFFC);
    popN(3, "t7_pop");

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
